// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter and the
// rotating-priority picker it shares with the read-side scheduler.
package fifo_arb_pkg;

    typedef enum logic {
        ARB = 1'b0,
        GNT = 1'b1
    } arb_state_e;

    function automatic int calc_id_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    function automatic int calc_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Widths for the default configuration (NUM_REQ=4, MAX_BURST=4).
    localparam int DEF_ID_W  = calc_id_w(4);
    localparam int DEF_CNT_W = calc_cnt_w(4);

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request
// searching upward, with wrap, from i_last_id + 1.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_id,
    output logic               o_any,
    output logic [ID_W-1:0]    o_pick_id
);

    int w_dist;
    int w_best;

    // Rotational distance 0 means "immediately after last_id"; smallest wins.
    always_comb begin
        o_any     = 1'b0;
        o_pick_id = '0;
        w_dist    = 0;
        w_best    = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(i_last_id)) % NUM_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                o_pick_id = ID_W'(i);
                o_any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// granting bounded bursts and never writing while the FIFO is full.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_wr_data,
    output logic                        grant_vld,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        dbg_state
);

    localparam int ID_W  = calc_id_w(NUM_REQ);
    localparam int CNT_W = calc_cnt_w(MAX_BURST);

    // Handshake: a beat moves on a rising edge when req_valid[i] && req_ready[i];
    // only the granted requester ever sees ready, and only while the FIFO is not full.

    arb_state_e        r_state;
    logic              r_grant_vld;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   r_last_id;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic              w_any;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_sel_valid;
    logic              w_xfer;
    logic              w_last_beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req     (req_valid),
        .i_last_id (r_last_id),
        .o_any     (w_any),
        .o_pick_id (w_pick_id)
    );

    assign w_sel_valid = req_valid[r_grant_id];
    assign w_xfer      = (r_state == GNT) && w_sel_valid && !fifo_full;
    assign w_last_beat = w_xfer && (r_beat_cnt == CNT_W'(MAX_BURST - 1));

    // Outputs are gated by r_state so an asynchronous reset drops them at once.
    always_comb begin
        req_ready    = '0;
        fifo_wr_data = '0;
        if (r_state == GNT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_grant_id == ID_W'(i)) begin
                    req_ready[i] = !fifo_full;
                    fifo_wr_data = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign fifo_wr_en = w_xfer;
    assign grant_vld  = r_grant_vld;
    assign grant_id   = r_grant_id;
    assign dbg_state  = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB;
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
            r_beat_cnt  <= '0;
            r_last_id   <= ID_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                ARB: begin
                    if (w_any) begin
                        r_grant_id  <= w_pick_id;
                        r_beat_cnt  <= '0;
                        r_grant_vld <= 1'b1;
                        r_state     <= GNT;
                    end
                end
                GNT: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                    // A full FIFO holds the grant; only a dropped valid or the burst limit releases it.
                    if (!w_sel_valid || w_last_beat) begin
                        r_last_id   <= r_grant_id;
                        r_grant_vld <= 1'b0;
                        r_state     <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: an 8-deep FIFO model, queued requesters and a
// per-cycle arbitration reference model, plus directed scenario checks.
module tb_fifo_wr_arb;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int MB    = 4;
    localparam int DEPTH = 8;
    localparam int QMAX  = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            grant_vld;
    logic [1:0]      grant_id;
    logic            dbg_state;

    fifo_wr_arb #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_vld    (grant_vld),
        .grant_id     (grant_id),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // requester word stores
    logic [DW-1:0] rq_mem [N][QMAX];
    int            rq_head [N];
    int            rq_tail [N];

    // FIFO model, write log and scoreboard
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] wlog_data [$];
    int            wlog_cyc [$];
    int            wlog_id [$];
    int            gseq [$];
    logic          fifo_rd = 1'b0;
    logic          prev_gv = 1'b0;
    int            wr_err = 0;
    int            cyc = 0;

    // reference arbitration model: owner -1 means nobody holds the grant
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = N - 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic push_word(input int r, input logic [DW-1:0] d);
        rq_mem[r][rq_tail[r]] = d;
        rq_tail[r]++;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (rq_tail[i] > rq_head[i]);
            req_data[i*DW +: DW] = req_valid[i] ? rq_mem[i][rq_head[i]] : DW'($urandom);
        end
        fifo_full = (fifo_q.size() == DEPTH);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
        prev_gv = 1'b0;
    endtask

    task automatic clear_logs();
        wlog_data.delete();
        wlog_cyc.delete();
        wlog_id.delete();
        gseq.delete();
        exp_q.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_rd = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        fifo_q.delete();
        wr_err = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    // One clock: drive, compare against the reference model, advance both worlds.
    task automatic cycle();
        logic [N-1:0]  exp_rdy;
        logic          exp_vld;
        logic          exp_wr;
        logic [DW-1:0] exp_dat;
        logic          a_wr;
        logic [DW-1:0] a_dat;
        logic          pre_full;
        logic          xfer;
        int            xid;
        int            nxt;
        drive_inputs();
        #1;
        exp_vld = (m_owner >= 0);
        exp_wr  = 1'b0;
        exp_rdy = '0;
        exp_dat = '0;
        if (exp_vld) begin
            exp_wr           = req_valid[m_owner] && !fifo_full;
            exp_rdy[m_owner] = !fifo_full;
            exp_dat          = req_data[m_owner*DW +: DW];
        end
        n_tests++;
        if (grant_vld !== exp_vld) begin
            n_fail++;
            $display("FAIL model_grant_vld cyc=%0d got=%b exp=%b", cyc, grant_vld, exp_vld);
        end
        n_tests++;
        if (dbg_state !== exp_vld) begin
            n_fail++;
            $display("FAIL model_state cyc=%0d got=%b exp=%b", cyc, dbg_state, exp_vld);
        end
        if (exp_vld) begin
            n_tests++;
            if (int'(grant_id) !== m_owner) begin
                n_fail++;
                $display("FAIL model_grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, m_owner);
            end
        end
        n_tests++;
        if (fifo_wr_en !== exp_wr) begin
            n_fail++;
            $display("FAIL model_wr_en cyc=%0d got=%b exp=%b", cyc, fifo_wr_en, exp_wr);
        end
        n_tests++;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL model_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
        end
        n_tests++;
        if (fifo_wr_data !== exp_dat) begin
            n_fail++;
            $display("FAIL model_wr_data cyc=%0d got=%h exp=%h", cyc, fifo_wr_data, exp_dat);
        end
        if (grant_vld && !prev_gv) gseq.push_back(int'(grant_id));
        prev_gv  = grant_vld;
        a_wr     = fifo_wr_en;
        a_dat    = fifo_wr_data;
        pre_full = fifo_full;
        xfer     = exp_wr;
        xid      = m_owner;
        if (m_owner < 0) begin
            nxt = -1;
            for (int k = N; k >= 1; k--) begin
                if (req_valid[(m_last + k) % N]) nxt = (m_last + k) % N;
            end
            if (nxt >= 0) begin
                m_owner = nxt;
                m_beats = 0;
            end
        end else begin
            if (xfer) m_beats++;
            if (!req_valid[m_owner] || m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        @(posedge clk);
        if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (a_wr) begin
            if (pre_full) begin
                wr_err++;
            end else begin
                fifo_q.push_back(a_dat);
                wlog_data.push_back(a_dat);
                wlog_cyc.push_back(cyc);
                wlog_id.push_back(xid);
            end
        end
        if (xfer) rq_head[xid]++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        #1;
        n_tests++;
        if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL reset_grant_vld got=%b exp=0", grant_vld); end
        n_tests++;
        if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        n_tests++;
        if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
        n_tests++;
        if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        n_tests++;
        if (fifo_wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data got=%h exp=0", fifo_wr_data); end
        n_tests++;
        if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
        do_reset();
    endtask

    task automatic test_single_burst();
        int exp_cyc [6];
        exp_cyc = '{1, 2, 3, 4, 6, 7};
        do_reset();
        fifo_rd = 1'b1;
        for (int j = 0; j < 6; j++) push_word(0, DW'(32'h10 + j));
        for (int c = 0; c < 10; c++) cycle();
        n_tests++;
        if (wlog_data.size() != 6) begin
            n_fail++;
            $display("FAIL burst_count got=%0d exp=6", wlog_data.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                n_tests++;
                if (wlog_data[j] !== DW'(32'h10 + j) || wlog_cyc[j] != exp_cyc[j]) begin
                    n_fail++;
                    $display("FAIL burst_beat%0d got=%h@%0d exp=%h@%0d", j, wlog_data[j], wlog_cyc[j], 32'h10 + j, exp_cyc[j]);
                end
            end
        end
        n_tests++;
        if (gseq.size() != 2 || gseq[0] != 0 || gseq[1] != 0) begin
            n_fail++;
            $display("FAIL burst_grants got_n=%0d exp=2 grants to id 0", gseq.size());
        end
    endtask

    task automatic test_round_robin();
        int exp_ids [5];
        exp_ids = '{0, 1, 2, 3, 0};
        do_reset();
        fifo_rd = 1'b1;
        for (int r = 0; r < N; r++)
            for (int j = 0; j < 30; j++) push_word(r, DW'($urandom));
        for (int g = 0; g < 5; g++)
            for (int j = 0; j < MB; j++) exp_q.push_back(rq_mem[exp_ids[g]][(g / N) * MB + j]);
        for (int c = 0; c < 26; c++) cycle();
        for (int g = 0; g < 5; g++) begin
            n_tests++;
            if (g >= gseq.size() || gseq[g] != exp_ids[g]) begin
                n_fail++;
                $display("FAIL rr_order grant%0d got=%0d exp=%0d", g, (g < gseq.size()) ? gseq[g] : -1, exp_ids[g]);
            end
        end
        n_tests++;
        if (wlog_data.size() < 20) begin
            n_fail++;
            $display("FAIL rr_count got=%0d exp>=20", wlog_data.size());
        end else begin
            for (int j = 0; j < 20; j++) begin
                n_tests++;
                if (wlog_data[j] !== exp_q[j] || (wlog_cyc[j] % (MB + 1)) == 0) begin
                    n_fail++;
                    $display("FAIL rr_word%0d got=%h@%0d exp=%h off-ARB", j, wlog_data[j], wlog_cyc[j], exp_q[j]);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        fifo_rd = 1'b0;
        for (int j = 0; j < 12; j++) push_word(1, DW'(32'h100 + j));
        for (int c = 0; c < 15; c++) cycle();
        drive_inputs();
        #1;
        n_tests++;
        if (fifo_q.size() != DEPTH || wlog_data.size() != DEPTH) begin
            n_fail++;
            $display("FAIL stall_fill got=%0d exp=%0d", wlog_data.size(), DEPTH);
        end
        n_tests++;
        if (fifo_wr_en !== 1'b0 || req_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_block got=wr%b/rdy%b exp=0/0", fifo_wr_en, req_ready[1]);
        end
        n_tests++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_hold got=%b/%0d exp=1/1", grant_vld, grant_id);
        end
        fifo_rd = 1'b1;
        cycle();
        fifo_rd = 1'b0;
        cycle();
        n_tests++;
        if (wlog_data.size() != DEPTH + 1 || wlog_data[DEPTH] !== DW'(32'h100 + DEPTH)) begin
            n_fail++;
            $display("FAIL stall_resume got_n=%0d exp_n=%0d", wlog_data.size(), DEPTH + 1);
        end
        n_tests++;
        if (wr_err != 0) begin n_fail++; $display("FAIL stall_wr_err got=%0d exp=0", wr_err); end
    endtask

    task automatic test_early_release();
        int exp_id [6];
        int exp_cy [6];
        exp_id = '{2, 2, 3, 3, 3, 3};
        exp_cy = '{1, 2, 5, 6, 7, 8};
        do_reset();
        fifo_rd = 1'b1;
        for (int j = 0; j < 2; j++) push_word(2, DW'(32'h200 + j));
        for (int j = 0; j < 4; j++) push_word(3, DW'(32'h300 + j));
        for (int c = 0; c < 12; c++) cycle();
        n_tests++;
        if (wlog_data.size() != 6) begin
            n_fail++;
            $display("FAIL early_count got=%0d exp=6", wlog_data.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                n_tests++;
                if (wlog_id[j] != exp_id[j] || wlog_cyc[j] != exp_cy[j]) begin
                    n_fail++;
                    $display("FAIL early_beat%0d got=id%0d@%0d exp=id%0d@%0d", j, wlog_id[j], wlog_cyc[j], exp_id[j], exp_cy[j]);
                end
            end
        end
        n_tests++;
        if (gseq.size() != 2 || gseq[0] != 2 || gseq[1] != 3) begin
            n_fail++;
            $display("FAIL early_grants got_n=%0d exp=2,3", gseq.size());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        fifo_rd = 1'b1;
        for (int j = 0; j < 6; j++) push_word(1, DW'(32'h400 + j));
        cycle();
        cycle();
        drive_inputs();
        #1;
        n_tests++;
        if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL mrst_pre got=wr%b/id%0d exp=1/1", fifo_wr_en, grant_id);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (fifo_wr_en !== 1'b0 || grant_vld !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL mrst_async got=wr%b/gv%b/rdy%b exp=0/0/0", fifo_wr_en, grant_vld, req_ready);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fifo_q.delete();
        clear_logs();
        for (int j = 0; j < 3; j++) push_word(0, DW'(32'h500 + j));
        for (int c = 0; c < 9; c++) cycle();
        n_tests++;
        if (gseq.size() < 2 || gseq[0] != 0 || gseq[1] != 1) begin
            n_fail++;
            $display("FAIL mrst_regrant got_first=%0d exp=0", (gseq.size() > 0) ? gseq[0] : -1);
        end
        n_tests++;
        if (wlog_data.size() < 4 || wlog_data[0] !== DW'(32'h500) || wlog_data[3] !== DW'(32'h401)) begin
            n_fail++;
            $display("FAIL mrst_words got_n=%0d exp first=500 fourth=401", wlog_data.size());
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 20; c++) cycle();
        n_tests++;
        if (dbg_state !== 1'b0 || wlog_data.size() != 0 || gseq.size() != 0) begin
            n_fail++;
            $display("FAIL idle got=st%b/wr%0d exp=0/0", dbg_state, wlog_data.size());
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = int'($urandom_range(0, N - 1));
            if ($urandom_range(0, 3) != 0 && rq_tail[r] < QMAX) push_word(r, DW'($urandom));
            fifo_rd = ($urandom_range(0, 2) != 0);
            cycle();
        end
        n_tests++;
        if (wr_err != 0) begin n_fail++; $display("FAIL rand_wr_err got=%0d exp=0", wr_err); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_mid_reset();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
